// File: rtl/ahb2apb_bridge_arbiter_if.sv
// AHB-Lite port bundle for the two-master APB bridge arbiter.
// The master modport drives the address phase and HREADY; the slave modport returns the response.
interface ahb2apb_bridge_arbiter_if #(
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned DATAWIDTH = 32
);
    logic                 hsel;
    logic [ADDRWIDTH-1:0] haddr;
    logic [1:0]           htrans;
    logic                 hwrite;
    logic [2:0]           hsize;
    logic [3:0]           hprot;
    logic [DATAWIDTH-1:0] hwdata;
    logic                 hready;
    logic                 hreadyout;
    logic [DATAWIDTH-1:0] hrdata;
    logic                 hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/ahb2apb_bridge_arbiter.sv
// Two-master AHB-Lite arbiter in front of the AHB2APB bridge slave port.
// Each master has an address-phase hold stage; grants alternate round-robin.
module ahb2apb_bridge_arbiter #(
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    ahb2apb_bridge_arbiter_if.slave         ahb_m0_io,
    ahb2apb_bridge_arbiter_if.slave         ahb_m1_io,
    ahb2apb_bridge_arbiter_if.master        ahb_s_io,
    output logic                            arbactive_o
);
    typedef struct packed {
        logic [ADDRWIDTH-1:0] addr;
        logic                 write;
        logic [2:0]           size;
        logic [3:0]           prot;
    } addr_t;

    addr_t [1:0] live_a;
    addr_t [1:0] hold_q, hold_d;
    addr_t       sel_a;
    logic  [1:0] live, grant, hreadyout_m, hresp_m;
    logic  [1:0] pend_q, pend_d;
    logic        rr_q, rr_d;
    logic        dp_valid_q, dp_valid_d;
    logic        dp_owner_q, dp_owner_d;
    logic        slot_free, winner;

    // BUSY and IDLE never count as requests.
    assign live[0] = ahb_m0_io.hsel & ahb_m0_io.hready & ahb_m0_io.htrans[1];
    assign live[1] = ahb_m1_io.hsel & ahb_m1_io.hready & ahb_m1_io.htrans[1];
    assign live_a[0] = '{addr: ahb_m0_io.haddr, write: ahb_m0_io.hwrite,
                         size: ahb_m0_io.hsize, prot: ahb_m0_io.hprot};
    assign live_a[1] = '{addr: ahb_m1_io.haddr, write: ahb_m1_io.hwrite,
                         size: ahb_m1_io.hsize, prot: ahb_m1_io.hprot};
    assign slot_free = ahb_s_io.hreadyout;

    always_comb begin
        grant = 2'b00;
        if (slot_free) begin
            if (pend_q == 2'b01)                  grant = 2'b01;
            else if (pend_q == 2'b10)             grant = 2'b10;
            else if ((live | pend_q) == 2'b11)    grant = rr_q ? 2'b01 : 2'b10;
            else                                  grant = live;
        end
    end

    assign winner = grant[1];
    assign sel_a  = pend_q[winner] ? hold_q[winner] : live_a[winner];

    always_comb begin
        pend_d     = pend_q;
        hold_d     = hold_q;
        rr_d       = rr_q;
        dp_valid_d = dp_valid_q;
        dp_owner_d = dp_owner_q;
        for (int n = 0; n < 2; n++) begin
            if (grant[n] && pend_q[n]) begin
                pend_d[n] = 1'b0;
            end else if (live[n] && !grant[n] && !pend_q[n]) begin
                pend_d[n] = 1'b1;
                hold_d[n] = live_a[n];
            end
        end
        if (|grant) begin
            rr_d       = winner;
            dp_valid_d = 1'b1;
            dp_owner_d = winner;
        end else if (slot_free) begin
            dp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q     <= 2'b00;
            hold_q     <= '0;
            rr_q       <= 1'b1;
            dp_valid_q <= 1'b0;
            dp_owner_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            rr_q       <= rr_d;
            dp_valid_q <= dp_valid_d;
            dp_owner_q <= dp_owner_d;
        end
    end

    // The data-phase owner follows the bridge; anyone else waiting is stalled.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            hresp_m[n] = 1'b0;
            if (dp_valid_q && (dp_owner_q == 1'(n))) begin
                hreadyout_m[n] = ahb_s_io.hreadyout;
                hresp_m[n]     = ahb_s_io.hresp;
            end else if (pend_q[n] || (live[n] && !grant[n])) begin
                hreadyout_m[n] = 1'b0;
            end else begin
                hreadyout_m[n] = 1'b1;
            end
        end
    end

    assign ahb_s_io.hsel   = |grant;
    assign ahb_s_io.htrans = (|grant) ? 2'b10 : 2'b00;
    assign ahb_s_io.haddr  = (|grant) ? sel_a.addr  : '0;
    assign ahb_s_io.hwrite = (|grant) ? sel_a.write : 1'b0;
    assign ahb_s_io.hsize  = (|grant) ? sel_a.size  : 3'b000;
    assign ahb_s_io.hprot  = (|grant) ? sel_a.prot  : 4'b0000;
    assign ahb_s_io.hwdata = dp_owner_q ? ahb_m1_io.hwdata : ahb_m0_io.hwdata;
    assign ahb_s_io.hready = ahb_s_io.hreadyout;

    assign ahb_m0_io.hreadyout = hreadyout_m[0];
    assign ahb_m1_io.hreadyout = hreadyout_m[1];
    assign ahb_m0_io.hresp     = hresp_m[0];
    assign ahb_m1_io.hresp     = hresp_m[1];
    assign ahb_m0_io.hrdata    = ahb_s_io.hrdata;
    assign ahb_m1_io.hrdata    = ahb_s_io.hrdata;

    assign arbactive_o = |pend_q | dp_valid_q;
endmodule
